// File: rtl/multi7_scan.sv
// Multiplexed seven-segment scanner: per-frame input snapshot, dead time between slots,
// PWM brightness, per-digit blank/blink/dp, leading-zero suppression and selectable polarity.
module multi7_scan #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned DIGIT_CYCLES   = 135_000,
  parameter int unsigned BLANK_CYCLES   = 27,
  parameter int unsigned BRIGHT_BITS    = 4,
  parameter int unsigned BLINK_FRAMES   = 50,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [DIGITS*4-1:0]      i_digits,
  input  logic [DIGITS-1:0]        i_dp,
  input  logic [DIGITS-1:0]        i_blank,
  input  logic [DIGITS-1:0]        i_blink,
  input  logic                     i_lz_en,
  input  logic [BRIGHT_BITS-1:0]   i_brightness,
  output logic [6:0]               o_segments,
  output logic                     o_dp,
  output logic [DIGITS-1:0]        o_displays,
  output logic                     o_frame
);

  localparam int unsigned TICK_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int unsigned SEL_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned FR_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned ON_W   = $clog2(DIGIT_CYCLES) + BRIGHT_BITS + 1;

  localparam logic [6:0]        SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] DIG_OFF = {DIGITS{DIG_ACTIVE_LOW}};

  // Hex nibble to active-high segments, bit6=a .. bit0=g.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_to_seg = 7'h7E;
      4'h1: hex_to_seg = 7'h30;
      4'h2: hex_to_seg = 7'h6D;
      4'h3: hex_to_seg = 7'h79;
      4'h4: hex_to_seg = 7'h33;
      4'h5: hex_to_seg = 7'h5B;
      4'h6: hex_to_seg = 7'h5F;
      4'h7: hex_to_seg = 7'h70;
      4'h8: hex_to_seg = 7'h7F;
      4'h9: hex_to_seg = 7'h7B;
      4'hA: hex_to_seg = 7'h77;
      4'hB: hex_to_seg = 7'h1F;
      4'hC: hex_to_seg = 7'h4E;
      4'hD: hex_to_seg = 7'h3D;
      4'hE: hex_to_seg = 7'h4F;
      default: hex_to_seg = 7'h47;
    endcase
  endfunction

  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [FR_W-1:0]     fcnt_q, fcnt_d;
  logic                phase_q, phase_d;
  logic [DIGITS*4-1:0] dig_sh_q, dig_sh_d;
  logic [DIGITS-1:0]   dp_sh_q, dp_sh_d;
  logic [DIGITS-1:0]   blank_sh_q, blank_sh_d;
  logic [DIGITS-1:0]   blink_sh_q, blink_sh_d;
  logic                lz_sh_q, lz_sh_d;
  logic [ON_W-1:0]     on_q, on_d;
  logic [6:0]          seg_q, seg_d;
  logic                dpo_q, dpo_d;
  logic [DIGITS-1:0]   disp_q, disp_d;
  logic                frame_q, frame_d;

  logic                tick_end, sel_end, fr_end, snap;
  logic [DIGITS-1:0]   supp, onehot;
  logic                all_zero, cur_dp, cur_dark, in_win, lit;
  logic [3:0]          cur_nib;

  // Scan counters, snapshot capture and blink phase.
  always_comb begin
    tick_d     = tick_q;
    sel_d      = sel_q;
    fcnt_d     = fcnt_q;
    phase_d    = phase_q;
    dig_sh_d   = dig_sh_q;
    dp_sh_d    = dp_sh_q;
    blank_sh_d = blank_sh_q;
    blink_sh_d = blink_sh_q;
    lz_sh_d    = lz_sh_q;
    on_d       = on_q;

    tick_end = (tick_q == TICK_W'(DIGIT_CYCLES - 1));
    sel_end  = (sel_q == SEL_W'(DIGITS - 1));
    fr_end   = (fcnt_q == FR_W'(BLINK_FRAMES - 1));
    snap     = (sel_q == '0) && (tick_q == '0);

    tick_d = tick_end ? '0 : tick_q + TICK_W'(1);
    if (tick_end) begin
      sel_d = sel_end ? '0 : sel_q + SEL_W'(1);
      // Frame count advances on the last clock of a frame so a new phase starts with the next frame.
      if (sel_end) begin
        fcnt_d = fr_end ? '0 : fcnt_q + FR_W'(1);
        if (fr_end) phase_d = ~phase_q;
      end
    end

    if (snap) begin
      dig_sh_d   = i_digits;
      dp_sh_d    = i_dp;
      blank_sh_d = i_blank;
      blink_sh_d = i_blink;
      lz_sh_d    = i_lz_en;
      on_d       = ON_W'((ON_W'(DIGIT_CYCLES - BLANK_CYCLES)
                          * (ON_W'(i_brightness) + ON_W'(1))) >> BRIGHT_BITS);
    end
  end

  // Suppression, current-digit select and registered pin values.
  always_comb begin
    supp     = '0;
    onehot   = '0;
    all_zero = 1'b1;
    cur_nib  = 4'h0;
    cur_dp   = 1'b0;
    cur_dark = 1'b1;

    for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
      if (dig_sh_q[4*k +: 4] != 4'h0) all_zero = 1'b0;
      supp[k] = lz_sh_q && (k != 0) && all_zero;
    end

    for (int k = 0; k < int'(DIGITS); k++) begin
      if (sel_q == SEL_W'(k)) begin
        cur_nib   = dig_sh_q[4*k +: 4];
        cur_dp    = dp_sh_q[k];
        cur_dark  = blank_sh_q[k] | (blink_sh_q[k] & phase_q) | supp[k];
        onehot[k] = 1'b1;
      end
    end

    in_win = (ON_W'(tick_q) >= ON_W'(BLANK_CYCLES))
          && (ON_W'(tick_q) < ON_W'(BLANK_CYCLES) + on_q);
    lit    = in_win && !cur_dark;

    seg_d   = (lit ? hex_to_seg(cur_nib) : 7'h00) ^ SEG_OFF;
    dpo_d   = (lit & cur_dp) ^ SEG_ACTIVE_LOW;
    disp_d  = (lit ? onehot : '0) ^ DIG_OFF;
    frame_d = snap;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tick_q     <= '0;
      sel_q      <= '0;
      fcnt_q     <= '0;
      phase_q    <= 1'b0;
      dig_sh_q   <= '0;
      dp_sh_q    <= '0;
      blank_sh_q <= '0;
      blink_sh_q <= '0;
      lz_sh_q    <= 1'b0;
      on_q       <= '0;
      seg_q      <= SEG_OFF;
      dpo_q      <= SEG_ACTIVE_LOW;
      disp_q     <= DIG_OFF;
      frame_q    <= 1'b0;
    end else begin
      tick_q     <= tick_d;
      sel_q      <= sel_d;
      fcnt_q     <= fcnt_d;
      phase_q    <= phase_d;
      dig_sh_q   <= dig_sh_d;
      dp_sh_q    <= dp_sh_d;
      blank_sh_q <= blank_sh_d;
      blink_sh_q <= blink_sh_d;
      lz_sh_q    <= lz_sh_d;
      on_q       <= on_d;
      seg_q      <= seg_d;
      dpo_q      <= dpo_d;
      disp_q     <= disp_d;
      frame_q    <= frame_d;
    end
  end

  assign o_segments = seg_q;
  assign o_dp       = dpo_q;
  assign o_displays = disp_q;
  assign o_frame    = frame_q;

endmodule

// File: doc/multi7_scan.md
# multi7_scan

Parametrised multiplexed seven-segment scanner: the next generation of the existing single-mode multiplexed display driver. It drives DIGITS common-anode or common-cathode displays from packed hex nibbles. It adds a per-frame input snapshot (no tearing), anti-ghost dead time, PWM brightness, per-digit blank/blink/decimal point, leading-zero suppression and selectable output polarities. It sits between the counter/status logic and the board's segment/digit pins.

## Interface
- DIGITS, 4: number of digits; ≥1.
- DIGIT_CYCLES, 135_000: clocks per digit slot (5 ms at 27 MHz).
- BLANK_CYCLES, 27: dead time at the start of each slot, all digits off; 2 ≤ BLANK_CYCLES < DIGIT_CYCLES.
- BRIGHT_BITS, 4: brightness code width.
- BLINK_FRAMES, 50: frames per blink half-period; ≥1.
- SEG_ACTIVE_LOW, 0: 1 = segment/dp outputs are driven low when lit.
- DIG_ACTIVE_LOW, 1: 1 = digit enables are driven low when selected.
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_digits  in  DIGITS*4  nibble k = digit k; digit 0 is least significant.
- i_dp  in  DIGITS  decimal point per digit.
- i_blank  in  DIGITS  force digit k dark.
- i_blink  in  DIGITS  digit k blinks.
- i_lz_en  in  1  leading-zero suppression enable.
- i_brightness  in  BRIGHT_BITS  duty code.
- o_segments  out  7  bit6=a … bit0=g.
- o_dp  out  1  decimal point.
- o_displays  out  DIGITS  digit enables.
- o_frame  out  1  one-cycle pulse when a new snapshot takes effect.

## Operation
- Counters:
  - tick runs 0..DIGIT_CYCLES-1.
  - sel runs 0..DIGITS-1 and advances when tick wraps; sel wraps to 0.
  - A frame is DIGITS*DIGIT_CYCLES clocks.
- Snapshot: on the clock edge where (sel,tick)=(0,0), all inputs are latched into shadow registers. The frame uses only shadow values; input changes mid-frame are ignored.
- Duty per snapshot: on = ((DIGIT_CYCLES-BLANK_CYCLES)*(b+1)) >> BRIGHT_BITS, where b = latched brightness.
  - Compute this at full width, clog2(DIGIT_CYCLES)+BRIGHT_BITS+1 bits, with no truncation before the shift.
  - Register the result with the snapshot.
  - b = max gives full on-time. b = 0 gives the minimum (nonzero) duty.
- Digit sel is lit when BLANK_CYCLES ≤ tick < BLANK_CYCLES+on and it is not dark.
- A digit is dark if any of the following holds:
  - its blank bit is set;
  - its blink bit is set while blink phase = 1;
  - it is suppressed.
- Suppression (i_lz_en=1): digit k>0 is suppressed if its nibble and every nibble above it are 0. Digit 0 is never suppressed.
- Dark or unlit digit: enable inactive, all segments and dp inactive.
- Blink: a frame counter runs 0..BLINK_FRAMES-1. Blink phase toggles at each wrap. Phase is 0 after reset.
- Decoding, hex to segments (active-high form):
  - 0:7E 1:30 2:6D 3:79 4:33 5:5B 6:5F 7:70
  - 8:7F 9:7B A:77 B:1F C:4E D:3D E:4F F:47
  - dp = latched i_dp[sel].
- Polarity: invert the segments and dp when SEG_ACTIVE_LOW. Invert o_displays when DIG_ACTIVE_LOW. The selected digit is one-hot before inversion.

## Timing
- All outputs are registered. Outputs in cycle n+1 reflect (sel,tick) and shadow state at cycle n.
- o_frame is high exactly in the cycle after the (0,0) edge, once per frame.
- Reset (i_rst_n low) takes effect immediately, including mid-slot or mid-frame:
  - all outputs go inactive: digits off, segments/dp off at configured polarity, o_frame = 0;
  - tick = 0, sel = 0, frame counter = 0, blink phase = 0, shadows cleared.
- First edge after release is (0,0): snapshot taken, o_frame pulses. With BLANK_CYCLES ≥ 2, the first lit cycle already uses the new shadow.
- Every slot boundary has at least BLANK_CYCLES dark clocks, so two enables are never active in the same cycle.
- A blink toggle takes effect at a frame start only.

## Test plan
Parameters: DIGITS=4, DIGIT_CYCLES=20, BLANK_CYCLES=4, BRIGHT_BITS=2, BLINK_FRAMES=2, DIG_ACTIVE_LOW=1, SEG_ACTIVE_LOW=0.
- Reset and scan:
  - Stimulus: hold reset, then release.
  - Required: during reset o_displays=1111 and o_segments=0.
  - Required after release: o_frame every 80 clocks; enables 1110, 1101, 1011, 0111 in order; never two enables low at once.
- Decode and full duty:
  - Stimulus: i_digits=0x0912, brightness=3.
  - Required: each digit lit 16 clocks and dark 4 per slot; segments per digit 6D, 30, 7B, 7E.
- Minimum duty and leading-zero suppression:
  - Stimulus: brightness=0, i_lz_en=1.
  - Required with i_digits=0x0007: only digit 0 lights, 4 clocks per slot, segments 70.
  - Required with i_digits=0x0000: only digit 0 lights, showing 7E.
- No tearing:
  - Stimulus: change i_digits from 0x1234 to 0x5678 at frame cycle 30.
  - Required: the rest of that frame still shows 1234; 5678 appears after the next o_frame.
- Blank, blink and dp:
  - Stimulus: i_blink=0001, i_blank=0100, i_dp=1000.
  - Required: digit 0 lit frames 0–1, dark frames 2–3, repeating; digit 2 never lit; o_dp high only in digit 3's lit cycles.
- Async reset mid-slot:
  - Stimulus: pull i_rst_n low at tick 10 of slot 2.
  - Required: all outputs inactive within the same cycle; scanning restarts from digit 0 after release.
